time_counter: RTL and testbench
===============================

# time_counter

Time-of-day counter for the digital clock. It consumes the divided clock level produced by the clock divider stage, sampled as data in the system clock domain. It converts each rising edge of that level into a one-second advance of a BCD hh:mm:ss register, and provides a set mode for manual adjustment. Its outputs drive the display multiplexer and any alarm/compare logic downstream.

## Interface
- `SYNC_EN`, 1: 1 = two-flop synchronizer on `i_tick_clk`; 0 = single sampling flop only, for a divider already in the `clk` domain.
- `MODE_24H`, 1: 1 = hours run 00..23; 0 = hours run 01..12.

- `clk`  in  1  system clock; the only clock in the block.
- `rst_n`  in  1  asynchronous, active-low reset.
- `i_tick_clk`  in  1  divided clock level. Each 0->1 transition is one second.
- `i_set_mode`  in  1  high = time frozen and manual increments enabled.
- `i_set_sel`  in  2  field select: 0 = seconds, 1 = minutes, 2 = hours, 3 = none.
- `i_set_inc`  in  1  single-cycle pulse; increments the selected field.
- `o_sec_bcd`  out  8  seconds; [7:4] tens, [3:0] units.
- `o_min_bcd`  out  8  minutes, BCD.
- `o_hour_bcd`  out  8  hours, BCD.
- `o_sec_pulse`  out  1  one-cycle pulse on every counted second.
- `o_day_wrap`  out  1  one-cycle pulse on the rollover to the day start.

## Operation
- **Edge detector**
  - The sample chain runs `s0`->`s1` (`s1` only when `SYNC_EN`=1), followed by history flop `prev`.
  - tick = newest sample & ~prev.
  - All chain flops, including `prev`, reset to 1. A divider that holds its output high through reset therefore produces no spurious tick at reset release. The first tick requires a real 0->1 transition.
- **Counting**, when tick=1 and `i_set_mode`=0:
  - Seconds units increment; 9->0 carries into seconds tens.
  - Seconds 59->00 carries into minutes. Minutes 59->00 carries into hours.
  - Hours: 23->00 when `MODE_24H`=1; 12->01 when `MODE_24H`=0.
- **Pulses**
  - `o_sec_pulse` is asserted on every counted second.
  - `o_day_wrap` is asserted only when the count advances from the last second of the day to the first: 23:59:59->00:00:00 (24h), or 12:59:59->01:00:00 (12h).
- **Set mode** (`i_set_mode`=1):
  - Ticks are discarded, not queued. The edge detector keeps tracking, so leaving set mode never produces a stale tick.
  - `i_set_inc` adds 1 to the selected field only, with no carry into the next field. Wrap points: seconds 59->00, minutes 59->00, hours per `MODE_24H`.
  - `i_set_sel`=3: `i_set_inc` is ignored.
  - `o_sec_pulse` and `o_day_wrap` stay 0.
- `i_set_inc` is ignored while `i_set_mode`=0.
- Every field holds valid BCD at all times; no nibble ever exceeds 9.

## Timing
- **Reset values**
  - `o_sec_bcd`=00, `o_min_bcd`=00, `o_hour_bcd`=00 (24h) or 12 (12h).
  - `o_sec_pulse`=0, `o_day_wrap`=0.
  - Edge-detect chain all 1.
- **Reset assertion:** asynchronous and immediate, including mid-carry. Release is synchronous to the next `clk` rising edge.
- **Tick latency.** Let E0 be the first `clk` edge that samples `i_tick_clk`=1.
  - `SYNC_EN`=1: tick is high between E1 and E2; the count updates at E2.
  - `SYNC_EN`=0: the count updates at E1.
- **Pulses:** all outputs are registered. `o_sec_pulse` and `o_day_wrap` are high for exactly the cycle following the update edge, coincident with the new count.
- **Short inputs:** an `i_tick_clk` high or low phase shorter than 2 `clk` periods (`SYNC_EN`=1) may be missed. No more than one tick is produced per rising transition.
- **`i_set_mode` sampling:** sampled on the same edge as tick. `i_set_mode`=1 on that edge discards the tick.
- **Increment latency:** `i_set_inc` takes effect on the edge that samples it; the new value is visible the next cycle. A held `i_set_inc` increments once per cycle.

## Test plan
- **Reset with input high:** hold `i_tick_clk`=1 across reset release for 10 cycles -> count stays 00:00:00 and `o_sec_pulse` never asserts.
- **Tick latency:** `SYNC_EN`=1, one 0->1 on `i_tick_clk` -> `o_sec_bcd`=01 exactly 2 edges after the first sampling edge, with `o_sec_pulse` high for 1 cycle.
- **Day rollover:** set 23:59:59, then apply one tick -> 00:00:00, `o_day_wrap`=1 for 1 cycle.
- **12h rollover:** `MODE_24H`=0, set 12:59:59, then apply one tick -> 01:00:00 with `o_day_wrap`=1. A further increment of hours 12 in set mode -> 01.
- **Set mode:** at 10:59:30, enter set mode and pulse `i_set_inc` with `i_set_sel`=1 -> 10:00:30 (no hour carry). Ticks during set mode leave seconds at 30. After exit, the next fresh edge -> 10:00:31.
- **Mid-operation reset:** assert `rst_n`=0 mid-count at 13:45:07 -> outputs go to 00:00:00 immediately, without waiting for a `clk` edge.

Source files
------------

// File: rtl/time_counter.sv
// BCD hh:mm:ss time-of-day counter advanced by rising edges of a divided clock level,
// with a set mode for manual per-field adjustment.
module time_counter #(
    parameter bit SYNC_EN  = 1'b1,
    parameter bit MODE_24H = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_tick_clk,
    input  logic       i_set_mode,
    input  logic [1:0] i_set_sel,
    input  logic       i_set_inc,
    output logic [7:0] o_sec_bcd,
    output logic [7:0] o_min_bcd,
    output logic [7:0] o_hour_bcd,
    output logic       o_sec_pulse,
    output logic       o_day_wrap
);

    localparam logic [7:0] HOUR_RST  = MODE_24H ? 8'h00 : 8'h12;
    localparam logic [7:0] HOUR_LAST = MODE_24H ? 8'h23 : 8'h12;

    typedef enum logic [1:0] {
        SEL_SEC  = 2'd0,
        SEL_MIN  = 2'd1,
        SEL_HOUR = 2'd2,
        SEL_NONE = 2'd3
    } set_sel_e;

    // Edge-detect chain resets high so a divider held high through reset gives no tick.
    logic s0_q;
    logic prev_q;
    logic sample;
    logic tick;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s0_q   <= 1'b1;
            prev_q <= 1'b1;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
            s0_q   <= i_tick_clk;
            prev_q <= sample;
        end
    end

    generate
        if (SYNC_EN) begin : g_sync
            logic s1_q;
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) s1_q <= 1'b1;
                else        s1_q <= s0_q;
            end
            assign sample = s1_q;
        end else begin : g_nosync
            assign sample = s0_q;
        end
    endgenerate

    assign tick = sample & ~prev_q;

    function automatic logic [7:0] inc_mod60(input logic [7:0] v);
        logic [7:0] r;
        if (v[3:0] == 4'd9) begin
            if (v[7:4] == 4'd5) r = 8'h00;
            else                r = {v[7:4] + 4'd1, 4'd0};
        end else begin
            r = {v[7:4], v[3:0] + 4'd1};
        end
        return r;
    endfunction

    function automatic logic [7:0] inc_hour(input logic [7:0] v);
        logic [7:0] r;
        if (v == HOUR_LAST)      r = MODE_24H ? 8'h00 : 8'h01;
        else if (v[3:0] == 4'd9) r = {v[7:4] + 4'd1, 4'd0};
        else                     r = {v[7:4], v[3:0] + 4'd1};
        return r;
    endfunction

    logic [7:0] sec_q, sec_d;
    logic [7:0] min_q, min_d;
    logic [7:0] hour_q, hour_d;
    logic       sec_pulse_q, sec_pulse_d;
    logic       day_wrap_q, day_wrap_d;

    always_comb begin
        // NOTE: every always_comb output gets a default first, so no path can infer a latch.
        sec_d       = sec_q;
        min_d       = min_q;
        hour_d      = hour_q;
        sec_pulse_d = 1'b0;
        day_wrap_d  = 1'b0;

        if (i_set_mode) begin
            if (i_set_inc) begin
                case (set_sel_e'(i_set_sel))
                    SEL_SEC:  sec_d  = inc_mod60(sec_q);
                    SEL_MIN:  min_d  = inc_mod60(min_q);
                    SEL_HOUR: hour_d = inc_hour(hour_q);
                    default:  ;
                endcase
            end
        end else if (tick) begin
            sec_d       = inc_mod60(sec_q);
            sec_pulse_d = 1'b1;
            if (sec_q == 8'h59) begin
                min_d = inc_mod60(min_q);
                if (min_q == 8'h59) begin
                    hour_d     = inc_hour(hour_q);
                    day_wrap_d = (hour_q == HOUR_LAST);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sec_q       <= 8'h00;
            min_q       <= 8'h00;
            hour_q      <= HOUR_RST;
            sec_pulse_q <= 1'b0;
            day_wrap_q  <= 1'b0;
        end else begin
            sec_q       <= sec_d;
            min_q       <= min_d;
            hour_q      <= hour_d;
            sec_pulse_q <= sec_pulse_d;
            day_wrap_q  <= day_wrap_d;
        end
    end

    assign o_sec_bcd   = sec_q;
    assign o_min_bcd   = min_q;
    assign o_hour_bcd  = hour_q;
    assign o_sec_pulse = sec_pulse_q;
    assign o_day_wrap  = day_wrap_q;

endmodule

// File: tb/tb_time_counter.sv
// Directed bench for time_counter: a 24h/2-flop-sync instance (index 0) and a
// 12h/single-flop instance (index 1) driven in one linear sequence.
module tb_time_counter;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       tick[2];
    logic       set_mode[2];
    logic [1:0] set_sel[2];
    logic       set_inc[2];
    logic [7:0] sec_bcd[2];
    logic [7:0] min_bcd[2];
    logic [7:0] hour_bcd[2];
    logic       sec_pulse[2];
    logic       day_wrap[2];

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        string       tag;
        int          dut;
        logic [23:0] t;
    } exp_t;
    exp_t sb[$];

    always #5 clk = ~clk;

    time_counter #(.SYNC_EN(1'b1), .MODE_24H(1'b1)) u_dut24 (
        .clk(clk), .rst_n(rst_n), .i_tick_clk(tick[0]), .i_set_mode(set_mode[0]),
        .i_set_sel(set_sel[0]), .i_set_inc(set_inc[0]), .o_sec_bcd(sec_bcd[0]),
        .o_min_bcd(min_bcd[0]), .o_hour_bcd(hour_bcd[0]), .o_sec_pulse(sec_pulse[0]),
        .o_day_wrap(day_wrap[0])
    );

    time_counter #(.SYNC_EN(1'b0), .MODE_24H(1'b0)) u_dut12 (
        .clk(clk), .rst_n(rst_n), .i_tick_clk(tick[1]), .i_set_mode(set_mode[1]),
        .i_set_sel(set_sel[1]), .i_set_inc(set_inc[1]), .o_sec_bcd(sec_bcd[1]),
        .o_min_bcd(min_bcd[1]), .o_hour_bcd(hour_bcd[1]), .o_sec_pulse(sec_pulse[1]),
        .o_day_wrap(day_wrap[1])
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic expect_time(input int d, input string tag, input logic [23:0] t);
        exp_t e;
        e.tag = tag;
        e.dut = d;
        e.t   = t;
        sb.push_back(e);
    endtask

    task automatic check_time();
        exp_t e;
        check("sb_nonempty", 32'(sb.size() != 0), 32'd1);
        if (sb.size() != 0) begin
            e = sb.pop_front();
            check(e.tag, {8'h00, hour_bcd[e.dut], min_bcd[e.dut], sec_bcd[e.dut]}, {8'h00, e.t});
        end
    endtask

    // Drive i_set_inc high for exactly n sampling edges on the selected field.
    task automatic inc_field(input int d, input logic [1:0] sel, input int n);
        @(negedge clk);
        set_sel[d] = sel;
        set_inc[d] = 1'b1;
        repeat (n) @(posedge clk);
        @(negedge clk);
        set_inc[d] = 1'b0;
    endtask

    // One 0->1 on the tick input; checks the update edge, pulse width and day wrap.
    task automatic pulse_tick(input int d, input string tag, input logic [23:0] t, input logic wrap);
        int lat = (d == 0) ? 2 : 1;
        expect_time(d, tag, t);
        @(negedge clk);
        tick[d] = 1'b1;
        for (int i = 0; i < lat; i++) begin
            @(negedge clk);
            check($sformatf("%s_pulse_early%0d", tag, i), 32'(sec_pulse[d]), 32'd0);
        end
        @(negedge clk);
        check_time();
        check({tag, "_pulse"}, 32'(sec_pulse[d]), 32'd1);
        check({tag, "_wrap"}, 32'(day_wrap[d]), 32'(wrap));
        @(negedge clk);
        check({tag, "_pulse_end"}, 32'(sec_pulse[d]), 32'd0);
        check({tag, "_wrap_end"}, 32'(day_wrap[d]), 32'd0);
        tick[d] = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0;
        for (int d = 0; d < 2; d++) begin
            tick[d]     = 1'b1;
            set_mode[d] = 1'b0;
            set_sel[d]  = 2'd3;
            set_inc[d]  = 1'b0;
        end

        // Reset values with the tick input held high through release
        repeat (3) @(negedge clk);
        expect_time(0, "rst_a", 24'h000000);
        check_time();
        expect_time(1, "rst_b", 24'h120000);
        check_time();
        check("rst_pulse_a", 32'(sec_pulse[0]), 32'd0);
        check("rst_wrap_a", 32'(day_wrap[0]), 32'd0);
        check("rst_pulse_b", 32'(sec_pulse[1]), 32'd0);
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check($sformatf("hi_rel_pulse_a%0d", i), 32'(sec_pulse[0]), 32'd0);
            check($sformatf("hi_rel_pulse_b%0d", i), 32'(sec_pulse[1]), 32'd0);
        end
        expect_time(0, "hi_rel_a", 24'h000000);
        check_time();
        expect_time(1, "hi_rel_b", 24'h120000);
        check_time();
        tick[0] = 1'b0;
        tick[1] = 1'b0;
        repeat (3) @(negedge clk);

        // 24h instance: tick latency, run-mode inc ignored, day rollover
        pulse_tick(0, "lat_a", 24'h000001, 1'b0);
        set_sel[0] = 2'd0;
        set_inc[0] = 1'b1;
        @(negedge clk);
        set_inc[0] = 1'b0;
        @(negedge clk);
        expect_time(0, "run_inc_ignored", 24'h000001);
        check_time();

        set_mode[0] = 1'b1;
        inc_field(0, 2'd2, 23);
        inc_field(0, 2'd1, 59);
        inc_field(0, 2'd0, 58);
        expect_time(0, "set_235959", 24'h235959);
        check_time();
        inc_field(0, 2'd3, 5);
        expect_time(0, "sel3_ignored", 24'h235959);
        check_time();
        set_mode[0] = 1'b0;
        pulse_tick(0, "day_wrap_24", 24'h000000, 1'b1);

        // Set mode: no carry, ticks discarded, no stale tick on exit
        set_mode[0] = 1'b1;
        inc_field(0, 2'd2, 10);
        inc_field(0, 2'd1, 59);
        inc_field(0, 2'd0, 30);
        expect_time(0, "set_105930", 24'h105930);
        check_time();
        inc_field(0, 2'd1, 1);
        expect_time(0, "min_no_carry", 24'h100030);
        check_time();
        for (int k = 0; k < 2; k++) begin
            tick[0] = 1'b1;
            repeat (4) @(negedge clk);
            check($sformatf("setmode_pulse%0d", k), 32'(sec_pulse[0]), 32'd0);
            tick[0] = 1'b0;
            repeat (4) @(negedge clk);
        end
        tick[0] = 1'b1;
        repeat (4) @(negedge clk);
        expect_time(0, "setmode_ticks_dropped", 24'h100030);
        check_time();
        set_mode[0] = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check($sformatf("no_stale_pulse%0d", i), 32'(sec_pulse[0]), 32'd0);
        end
        expect_time(0, "no_stale_time", 24'h100030);
        check_time();
        tick[0] = 1'b0;
        repeat (3) @(negedge clk);
        pulse_tick(0, "fresh_edge", 24'h100031, 1'b0);

        // 12h instance: single-flop latency, 12:59:59 rollover, hour wrap in set mode
        pulse_tick(1, "lat_b", 24'h120001, 1'b0);
        set_mode[1] = 1'b1;
        inc_field(1, 2'd1, 59);
        inc_field(1, 2'd0, 58);
        expect_time(1, "set_125959", 24'h125959);
        check_time();
        set_mode[1] = 1'b0;
        pulse_tick(1, "day_wrap_12", 24'h010000, 1'b1);
        set_mode[1] = 1'b1;
        inc_field(1, 2'd2, 8);
        expect_time(1, "hour_09", 24'h090000);
        check_time();
        inc_field(1, 2'd2, 1);
        expect_time(1, "hour_10", 24'h100000);
        check_time();
        inc_field(1, 2'd2, 2);
        expect_time(1, "hour_12", 24'h120000);
        check_time();
        inc_field(1, 2'd2, 1);
        expect_time(1, "hour_12_to_01", 24'h010000);
        check_time();
        set_mode[1] = 1'b0;

        // Mid-operation asynchronous reset at 13:45:07
        set_mode[0] = 1'b1;
        inc_field(0, 2'd2, 3);
        inc_field(0, 2'd1, 45);
        inc_field(0, 2'd0, 36);
        expect_time(0, "set_134507", 24'h134507);
        check_time();
        set_mode[0] = 1'b0;
        @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        expect_time(0, "async_rst_a", 24'h000000);
        check_time();
        expect_time(1, "async_rst_b", 24'h120000);
        check_time();
        check("async_rst_pulse_a", 32'(sec_pulse[0]), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
